aes_core_nk: RTL and testbench

AES_CORE_NK -- requirements
Module: aes_core_nk

---
 rtl/aes_core_nk.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_aes_core_nk.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_core_nk.sv
// aes_core_nk: iterative AES encryption core for 128/192/256-bit keys.
// Each round takes two cycles: SUB (registered SubBytes) and RND (ShiftRows,
// MixColumns, AddRoundKey). o_valid rises 2*NR cycles after acceptance.
// Ports: clk, rst (sync, active-high); i_valid/o_ready request handshake with
// i_plaintext (128) and i_key (32*NK); o_valid/i_ready result handshake with
// o_ciphertext (128, registered); o_busy (not IDLE); o_round (0 in IDLE).
// Optional macro AES_ABORT_EN adds i_abort: drops an in-flight request
// during SUB/RND and returns to IDLE, leaving o_ciphertext untouched.
// Also contains aes_core_nk_pkg (GF/AES helpers), subbytes_generic and
// aes_key_schedule.

package aes_core_nk_pkg;
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            p  = p ^ (b[i] ? aa : 8'h00);
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0), then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Byte k of the block sits at bits [127-8k -: 8]; row = k%4, column = k/4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction
endpackage

// SubBytes over a full block; MODE 0 registers the result, other modes are combinational.
module subbytes_generic #(
    parameter int MODE = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] i_data,
    output logic [127:0] o_data
);
    import aes_core_nk_pkg::*;

    logic [127:0] w_sub;

    // Sixteen parallel S-box lookups.
    always_comb begin
        w_sub = 128'h0;
        for (int k = 0; k < 16; k++) begin
            w_sub[127-8*k -: 8] = sbox(i_data[127-8*k -: 8]);
        end
    end

    if (MODE == 0) begin : g_reg
        logic [127:0] r_data;
        // Output register, cleared by the (synchronous) active-low reset.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_data <= 128'h0;
            end else begin
                r_data <= w_sub;
            end
        end
        assign o_data = r_data;
    end else begin : g_comb
        assign o_data = w_sub;
    end
endmodule

// Combinational FIPS-197 key expansion; round key r is the r-th 128-bit slice from the MSB end.
module aes_key_schedule #(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic [32*NK-1:0]      i_key,
    output logic [128*(NR+1)-1:0] o_expanded
);
    import aes_core_nk_pkg::*;

    function automatic logic [128*(NR+1)-1:0] expand_key(input logic [32*NK-1:0] key);
        logic [31:0]             w [4*(NR+1)];
        logic [31:0]             t;
        logic [7:0]              rc;
        logic [128*(NR+1)-1:0]   o;
        rc = 8'h01;
        o  = '0;
        for (int i = 0; i < NK; i++) begin
            w[i] = key[32*NK-1-32*i -: 32];
        end
        for (int i = NK; i < 4*(NR+1); i++) begin
            t = w[i-1];
            if (i % NK == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = xtime(rc);
            end else if (NK > 6 && i % NK == 4) begin
                t = sub_word(t);
            end else begin
                t = w[i-1];
            end
            w[i] = w[i-NK] ^ t;
        end
        for (int i = 0; i < 4*(NR+1); i++) begin
            o[128*(NR+1)-1-32*i -: 32] = w[i];
        end
        return o;
    endfunction

    assign o_expanded = expand_key(i_key);
endmodule

module aes_core_nk #(
    parameter int NK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [127:0]      i_plaintext,
    input  logic [32*NK-1:0]  i_key,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [127:0]      o_ciphertext,
    output logic              o_busy,
    output logic [3:0]        o_round
`ifdef AES_ABORT_EN
    ,
    input  logic              i_abort
`endif
);
    import aes_core_nk_pkg::*;

    localparam int         NR   = NK + 6;
    localparam logic [3:0] NR_L = 4'(NR);

    if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
        $error("aes_core_nk: NK must be 4, 6 or 8");
    end

    typedef enum logic [1:0] {IDLE, SUB, RND, DONE} fsm_t;

    fsm_t                  r_fsm, w_fsm_next;
    logic                  r_ready, r_valid, r_busy;
    logic [127:0]          r_state, r_ct;
    logic [32*NK-1:0]      r_key;
    logic [3:0]            r_round;
    logic [128*(NR+1)-1:0] w_expanded;
    logic [127:0]          w_rk_arr [NR+1];
    logic [127:0]          w_rk, w_sbox_out, w_sr, w_rnd_out;
    logic                  w_accept, w_abort, w_rst_n;

`ifdef AES_ABORT_EN
    assign w_abort = i_abort && (r_fsm == SUB || r_fsm == RND);
`else
    assign w_abort = 1'b0;
`endif

    assign w_accept = i_valid && r_ready;
    assign w_rst_n  = ~rst;

    aes_key_schedule #(.NK(NK), .NR(NR)) u_ks (
        .i_key      (r_key),
        .o_expanded (w_expanded)
    );

    for (genvar r = 0; r <= NR; r++) begin : g_rk
        assign w_rk_arr[r] = w_expanded[128*(NR+1)-1-128*r -: 128];
    end
    assign w_rk = w_rk_arr[r_round];

    subbytes_generic #(.MODE(0)) u_sb (
        .clk    (clk),
        .rst_n  (w_rst_n),
        .i_data (r_state),
        .o_data (w_sbox_out)
    );

    // The last round skips MixColumns.
    assign w_sr      = shift_rows(w_sbox_out);
    assign w_rnd_out = (r_round == NR_L) ? (w_sr ^ w_rk) : (mix_columns(w_sr) ^ w_rk);

    // Next-state logic.
    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            IDLE: begin
                if (w_accept) w_fsm_next = SUB;
                else          w_fsm_next = IDLE;
            end
            SUB: begin
                if (w_abort) w_fsm_next = IDLE;
                else         w_fsm_next = RND;
            end
            RND: begin
                if (w_abort)               w_fsm_next = IDLE;
                else if (r_round == NR_L)  w_fsm_next = DONE;
                else                       w_fsm_next = SUB;
            end
            DONE: begin
                if (i_ready) w_fsm_next = IDLE;
                else         w_fsm_next = DONE;
            end
            default: w_fsm_next = IDLE;
        endcase
    end

    // State register; handshake/status outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm   <= IDLE;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_fsm   <= w_fsm_next;
            r_ready <= (w_fsm_next == IDLE);
            r_valid <= (w_fsm_next == DONE);
            r_busy  <= (w_fsm_next != IDLE);
        end
    end

    // Datapath: initial AddRoundKey on acceptance, one round per SUB/RND pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= 128'h0;
            r_key   <= '0;
            r_ct    <= 128'h0;
            r_round <= 4'd0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (w_accept) begin
                        r_key   <= i_key;
                        r_state <= i_plaintext ^ i_key[32*NK-1 -: 128];
                        r_round <= 4'd1;
                    end
                end
                SUB: begin
                    if (w_abort) r_round <= 4'd0;
                end
                RND: begin
                    if (w_abort) begin
                        r_round <= 4'd0;
                    end else begin
                        r_state <= w_rnd_out;
                        if (r_round == NR_L) r_ct    <= w_rnd_out;
                        else                 r_round <= r_round + 4'd1;
                    end
                end
                DONE: begin
                    if (i_ready) r_round <= 4'd0;
                end
                default: r_round <= 4'd0;
            endcase
        end
    end

    assign o_ready      = r_ready;
    assign o_valid      = r_valid;
    assign o_busy       = r_busy;
    assign o_round      = r_round;
    assign o_ciphertext = r_ct;
endmodule

// File: tb/tb_aes_core_nk.sv
// Self-checking bench for aes_core_nk: three instances (NK = 4, 6, 8) checked
// against a byte-level AES reference model and the FIPS-197 known answers.
module tb_aes_core_nk;
    localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KAT_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] KAT_CT [3] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                                            128'hdda97ca4864cdfe06eaf70a0ec0d7191,
                                            128'h8ea2b7ca516745bfeafc49904b496089};

    logic         clk = 1'b0;
    logic         rst, i_ready;
    logic [127:0] pt;
    logic [255:0] key;
    logic [2:0]   vld, rdy, ov, busy;
    logic [127:0] ct  [3];
    logic [3:0]   rnd [3];
`ifdef AES_ABORT_EN
    logic         abort_s;
`endif
    logic [7:0]   sb [256];
    int           err_cnt = 0;
    int           chk_cnt = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_core_nk #(.NK(4 + 2*g)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .i_valid      (vld[g]),
            .o_ready      (rdy[g]),
            .i_plaintext  (pt),
            .i_key        (key[255 -: 32*(4+2*g)]),
            .o_valid      (ov[g]),
            .i_ready      (i_ready),
            .o_ciphertext (ct[g]),
            .o_busy       (busy[g]),
            .o_round      (rnd[g])
`ifdef AES_ABORT_EN
            ,
            .i_abort      (abort_s)
`endif
        );
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m2(input logic [7:0] a);
        return (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box table from the generator walk (multiply by 3 / divide by 3).
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    // Byte-oriented textbook AES encryption.
    function automatic logic [127:0] aes_model(input logic [127:0] p_in, input logic [255:0] k_in, input int nk);
        logic [7:0]   w [240];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   tw [4];
        logic [7:0]   rc, tmp;
        logic [127:0] o;
        int           nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < 4*nk; i++) w[i] = k_in[255-8*i -: 8];
        for (int i = nk; i < 4*(nr+1); i++) begin
            for (int k = 0; k < 4; k++) tw[k] = w[4*(i-1)+k];
            if (i % nk == 0) begin
                tmp = tw[0]; tw[0] = tw[1]; tw[1] = tw[2]; tw[2] = tw[3]; tw[3] = tmp;
                for (int k = 0; k < 4; k++) tw[k] = sb[tw[k]];
                tw[0] = tw[0] ^ rc;
                rc = m2(rc);
            end else if (nk == 8 && i % nk == 4) begin
                for (int k = 0; k < 4; k++) tw[k] = sb[tw[k]];
            end
            for (int k = 0; k < 4; k++) w[4*i+k] = w[4*(i-nk)+k] ^ tw[k];
        end
        for (int k = 0; k < 16; k++) s[k] = p_in[127-8*k -: 8] ^ w[k];
        for (int r = 1; r <= nr; r++) begin
            for (int k = 0; k < 16; k++) t[k] = sb[s[k]];
            for (int c = 0; c < 4; c++)
                for (int rw = 0; rw < 4; rw++) s[4*c+rw] = t[4*((c+rw)%4)+rw];
            if (r < nr) begin
                for (int c = 0; c < 4; c++) begin
                    for (int k = 0; k < 4; k++) tw[k] = s[4*c+k];
                    s[4*c+0] = m2(tw[0]) ^ m2(tw[1]) ^ tw[1] ^ tw[2] ^ tw[3];
                    s[4*c+1] = tw[0] ^ m2(tw[1]) ^ m2(tw[2]) ^ tw[2] ^ tw[3];
                    s[4*c+2] = tw[0] ^ tw[1] ^ m2(tw[2]) ^ m2(tw[3]) ^ tw[3];
                    s[4*c+3] = m2(tw[0]) ^ tw[0] ^ tw[1] ^ tw[2] ^ m2(tw[3]);
                end
            end
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ w[16*r+k];
        end
        for (int k = 0; k < 16; k++) o[127-8*k -: 8] = s[k];
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One request on instance g; optionally holds i_ready low 5 cycles in DONE.
    task automatic run_one(input int g, input logic [127:0] p_in, input logic [255:0] k_in,
                           input bit stall, output logic [127:0] res);
        int           nr, n;
        logic [127:0] exp;
        nr  = 4 + 2*g + 6;
        exp = aes_model(p_in, k_in, 4 + 2*g);
        n = 0;
        while (!rdy[g] && n < 100) begin @(posedge clk); #1; n++; end
        chk("ready_before_req", 128'(rdy[g]), 128'd1);
        pt = p_in; key = k_in; vld[g] = 1'b1; i_ready = !stall;
        @(posedge clk); #1;
        vld[g] = 1'b0;
        pt = rnd128(); key = {rnd128(), rnd128()};
        chk("busy_after_accept", {busy[g], rnd[g]}, {1'b1, 4'd1});
        for (n = 1; n <= 100; n++) begin
            vld[g] = (n == 5);
            @(posedge clk); #1;
            if (ov[g]) break;
        end
        vld[g] = 1'b0;
        chk("latency", 128'(n), 128'(2*nr));
        chk("ciphertext", ct[g], exp);
        res = ct[g];
        if (stall) begin
            for (int k = 0; k < 5; k++) begin
                vld[g] = (k % 2 == 0);
                @(posedge clk); #1;
                chk("stall_valid", 128'(ov[g]), 128'd1);
                chk("stall_ct", ct[g], exp);
            end
            vld[g] = 1'b0;
            i_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("idle_after_hs", {rdy[g], ov[g], busy[g], rnd[g]}, {1'b1, 1'b0, 1'b0, 4'd0});
        chk("ct_retained", ct[g], exp);
    endtask

    initial begin
        logic [127:0] res;
        int           n;
        build_sbox();
        rst = 1'b1; vld = 3'b000; i_ready = 1'b1; pt = 128'h0; key = 256'h0;
`ifdef AES_ABORT_EN
        abort_s = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int g = 0; g < 3; g++) begin
            chk("reset_status", {rdy[g], ov[g], busy[g], rnd[g]}, {1'b1, 1'b0, 1'b0, 4'd0});
            chk("reset_ct", ct[g], 128'h0);
        end

        for (int g = 0; g < 3; g++) begin
            run_one(g, KAT_PT, KAT_KEY, 1'b0, res);
            chk("known_answer", res, KAT_CT[g]);
        end

        for (int it = 0; it < 3; it++)
            for (int g = 0; g < 3; g++)
                run_one(g, rnd128(), {rnd128(), rnd128()}, 1'b0, res);

        run_one(0, KAT_PT, KAT_KEY, 1'b1, res);

        // Reset in the middle of round 5.
        pt = rnd128(); key = {rnd128(), rnd128()}; vld[0] = 1'b1;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        n = 0;
        while (rnd[0] != 4'd5 && n < 40) begin @(posedge clk); #1; n++; end
        chk("reach_round5", 128'(rnd[0]), 128'd5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midreset_status", {rdy[0], ov[0], busy[0], rnd[0]}, {1'b1, 1'b0, 1'b0, 4'd0});
        chk("midreset_ct", ct[0], 128'h0);
        run_one(0, KAT_PT, KAT_KEY, 1'b0, res);
        chk("known_after_reset", res, KAT_CT[0]);

        // Reset coincident with an acceptance: nothing is taken.
        vld = 3'b111; rst = 1'b1;
        @(posedge clk); #1;
        vld = 3'b000; rst = 1'b0;
        for (int g = 0; g < 3; g++)
            chk("rst_wins", {rdy[g], busy[g], ct[g]}, {1'b1, 1'b0, 128'h0});

`ifdef AES_ABORT_EN
        run_one(0, KAT_PT, KAT_KEY, 1'b0, res);
        pt = rnd128(); key = {rnd128(), rnd128()}; vld[0] = 1'b1;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        n = 0;
        while (rnd[0] != 4'd3 && n < 40) begin @(posedge clk); #1; n++; end
        abort_s = 1'b1;
        @(posedge clk); #1;
        abort_s = 1'b0;
        chk("abort_status", {rdy[0], busy[0], rnd[0]}, {1'b1, 1'b0, 4'd0});
        chk("abort_ct_kept", ct[0], KAT_CT[0]);
        run_one(0, rnd128(), {rnd128(), rnd128()}, 1'b0, res);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
